// File: rtl/restador_serial.sv
// restador_serial: bit-serial subtractor, d = a - b - bi (mod 2^WIDTH), LSB first.
// It processes one bit per clock. Operands are latched on an accepted start,
// and done pulses for one cycle once the final bit and the borrow-out are written.
//
// Ports
//   clk       rising-edge clock
//   reset_L   asynchronous active-low reset
//   start     begin a subtraction (only sampled in IDLE)
//   a, b      minuend / subtrahend (WIDTH bits)
//   bi        borrow-in
//   busy      high in RUN and DONE
//   done      one-cycle pulse, d/bo valid
//   d, bo     difference and borrow-out; held until the next accepted start
//   pwr_cnt   saturating toggle count of the serial difference bit (PwrC != 0)
module restador_serial #(
   parameter int WIDTH = 8,
   parameter int PwrC  = 0
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic [15:0]      pwr_cnt
);

   localparam int IDXW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_sh, b_sh;   // latched operands, shifted right each RUN edge
   logic              br;
   logic [IDXW-1:0]   idx;
   logic              diff_bit, br_nx, last_bit;
   logic              accept, run_en;

   assign diff_bit = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign last_bit = (idx == IDXW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      run_en   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            run_en = 1'b1;
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         a_sh <= '0;
         b_sh <= '0;
         br   <= 1'b0;
         idx  <= '0;
         d    <= '0;
         bo   <= 1'b0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         br   <= bi;
         idx  <= '0;
      end else if (run_en) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         br   <= br_nx;
         idx  <= idx + 1'b1;
         // Only the bit currently being produced is written; the rest of d holds.
         for (int j = 0; j < WIDTH; j++)
            if (idx == IDXW'(j)) d[j] <= diff_bit;
         if (last_bit) bo <= br_nx;
      end
   end

   generate
      if (PwrC != 0) begin : g_pwr
         logic prev_bit;
         // prev_bit is cleared on accept, so a leading 1 counts as a toggle.
         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               prev_bit <= 1'b0;
               pwr_cnt  <= '0;
            end else if (accept) begin
               prev_bit <= 1'b0;
            end else if (run_en) begin
               prev_bit <= diff_bit;
               if ((diff_bit != prev_bit) && (pwr_cnt != 16'hFFFF))
                  pwr_cnt <= pwr_cnt + 16'd1;
            end
         end
      end else begin : g_no_pwr
         assign pwr_cnt = '0;
      end
   endgenerate

endmodule

// File: tb/tb_restador_serial.sv
// Directed bench for restador_serial: an 8-bit instance with power counting, an
// 8-bit instance without it (sharing the same stimulus) and a 4-bit instance
// swept over every operand combination against a - b - bi.
module tb_restador_serial;

   logic       clk = 1'b0;
   logic       reset_L = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       bi = 1'b0;

   logic       busy_p, done_p, bo_p;
   logic [7:0] d_p;
   logic [15:0] pwr_p;
   logic       busy_n, done_n, bo_n;
   logic [7:0] d_n;
   logic [15:0] pwr_n;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bi4 = 1'b0;
   logic       busy4, done4, bo4;
   logic [3:0] d4;
   logic [15:0] pwr4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   restador_serial #(.WIDTH(8), .PwrC(1)) u_p (
      .clk(clk), .reset_L(reset_L), .start(start), .a(a), .b(b), .bi(bi),
      .busy(busy_p), .done(done_p), .d(d_p), .bo(bo_p), .pwr_cnt(pwr_p));

   restador_serial #(.WIDTH(8), .PwrC(0)) u_n (
      .clk(clk), .reset_L(reset_L), .start(start), .a(a), .b(b), .bi(bi),
      .busy(busy_n), .done(done_n), .d(d_n), .bo(bo_n), .pwr_cnt(pwr_n));

   restador_serial #(.WIDTH(4), .PwrC(0)) u_4 (
      .clk(clk), .reset_L(reset_L), .start(start4), .a(a4), .b(b4), .bi(bi4),
      .busy(busy4), .done(done4), .d(d4), .bo(bo4), .pwr_cnt(pwr4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit operation, start accepted at the first edge. With hold set, start
   // stays high and operands are scrambled every cycle of the run.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                      input bit hold, input logic [7:0] exp_d, input logic exp_bo,
                      input string tag);
      a = av; b = bv; bi = biv; start = 1'b1;
      tick();
      chk({tag, " busy@N"}, busy_p, 1);
      chk({tag, " done@N"}, done_p, 0);
      if (!hold) start = 1'b0;
      for (int k = 1; k < 8; k++) begin
         if (hold) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
         end
         tick();
         chk({tag, " done early"}, done_p, 0);
         chk({tag, " busy run"}, busy_p, 1);
      end
      tick();
      chk({tag, " done"}, done_p, 1);
      chk({tag, " d"}, d_p, exp_d);
      chk({tag, " bo"}, bo_p, exp_bo);
      chk({tag, " d nopwr"}, d_n, exp_d);
      tick();
      chk({tag, " done off"}, done_p, 0);
      chk({tag, " busy off"}, busy_p, 0);
      chk({tag, " d hold"}, d_p, exp_d);
      chk({tag, " bo hold"}, bo_p, exp_bo);
   endtask

   initial begin
      logic [4:0] ref5;

      // Asynchronous reset, away from any clock edge.
      #2 reset_L = 1'b0;
      #1;
      chk("rst busy", busy_p, 0);
      chk("rst done", done_p, 0);
      chk("rst d", d_p, 0);
      chk("rst bo", bo_p, 0);
      chk("rst pwr", pwr_p, 0);
      #20 reset_L = 1'b1;   // released mid-cycle

      // Power counting: 0x55 toggles on every bit starting from a cleared prev.
      op8(8'h55, 8'h00, 1'b0, 0, 8'h55, 1'b0, "pwr1");
      chk("pwr1 cnt", pwr_p, 8);
      op8(8'h55, 8'h00, 1'b0, 0, 8'h55, 1'b0, "pwr2");
      chk("pwr2 cnt", pwr_p, 16);
      chk("pwr off cnt", pwr_n, 0);

      op8(8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, "basic");
      op8(8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, "under");
      op8(8'hFF, 8'h00, 1'b1, 0, 8'hFE, 1'b0, "ff-bi");
      op8(8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1, "wrap");

      // start held high with scrambled operands: result is from the latched pair.
      op8(8'h20, 8'h07, 1'b0, 1, 8'h19, 1'b0, "hold");
      op8(8'hF0, 8'h01, 1'b0, 0, 8'hEF, 1'b0, "reacc");

      // Mid-run reset: after edge N+4 only the low nibble is new (0x35 -> 5),
      // the high nibble still holds 0xE from the previous result.
      a = 8'h39; b = 8'h04; bi = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("mid partial d", d_p, 8'hE5);
      chk("mid busy", busy_p, 1);
      reset_L = 1'b0;
      #1;
      chk("mid rst d", d_p, 0);
      chk("mid rst busy", busy_p, 0);
      chk("mid rst bo", bo_p, 0);
      chk("mid rst pwr", pwr_p, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("mid rst no done", done_p, 0);
      end
      #2 reset_L = 1'b1;
      op8(8'h39, 8'h04, 1'b0, 0, 8'h35, 1'b0, "after rst");
      chk("pwr off end", pwr_n, 0);

      // 4-bit sweep against a 5-bit reference subtraction.
      for (int ai = 0; ai < 16; ai++)
         for (int bj = 0; bj < 16; bj++)
            for (int c = 0; c < 2; c++) begin
               a4 = 4'(ai); b4 = 4'(bj); bi4 = 1'(c); start4 = 1'b1;
               ref5 = {1'b0, a4} - {1'b0, b4} - {4'b0, bi4};
               tick();
               start4 = 1'b0;
               repeat (4) tick();
               chk("w4 done", done4, 1);
               chk("w4 d", d4, ref5[3:0]);
               chk("w4 bo", bo4, ref5[4]);
               tick();
            end
      chk("w4 pwr", pwr4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
